// File: rtl/rtx_pixel_collector_if.sv
// Tracer-result and frame-buffer write bus of the pixel collector.
// The slave side is the collector; the master side is the cores plus the frame-buffer model.
interface rtx_pixel_collector_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]           core_valid;
    logic [NUM_CORES-1:0]           core_ready;
    logic [NUM_CORES-1:0][10:0]     core_h;
    logic [NUM_CORES-1:0][9:0]      core_v;
    logic [NUM_CORES-1:0][2:0][7:0] core_color;
    logic [10:0]                    pixel_h;
    logic [9:0]                     pixel_v;
    logic [2:0][7:0]                new_color;
    logic                           new_color_valid;
    logic                           frame_done;
    logic [20:0]                    pixels_written;
    logic [15:0]                    dropped_count;

    modport master (
        output core_valid, core_h, core_v, core_color,
        input  core_ready, pixel_h, pixel_v, new_color, new_color_valid,
        input  frame_done, pixels_written, dropped_count
    );

    modport slave (
        input  core_valid, core_h, core_v, core_color,
        output core_ready, pixel_h, pixel_v, new_color, new_color_valid,
        output frame_done, pixels_written, dropped_count
    );
endinterface

// File: rtl/rtx_pixel_collector.sv
// Round-robin collector of tracer results into a small FIFO, replayed to the frame
// buffer's read-modify-write port with a settle / write / gap sequence per pixel.
module rtx_pixel_collector #(
    parameter int NUM_CORES     = 4,
    parameter int SIZE_H        = 1280,
    parameter int SIZE_V        = 720,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                 clk_rtx,
    input  logic                 rst,
    rtx_pixel_collector_if.slave bus
);
    localparam int PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TOTAL   = SIZE_H * SIZE_V;

    typedef enum logic [1:0] {IDLE, SETTLE, WRITE, GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [10:0]      pixel_h_q, pixel_h_d;
    logic [9:0]       pixel_v_q, pixel_v_d;
    logic [23:0]      new_color_q, new_color_d;
    logic             new_color_valid_q, new_color_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [20:0]      pixels_written_q, pixels_written_d;
    logic [15:0]      dropped_count_q, dropped_count_d;

    logic [44:0]      fifo_mem [2**AW];
    logic [AW:0]      fifo_occ;
    logic             fifo_full;
    logic             fifo_empty;
    logic [44:0]      head;
    logic [44:0]      push_data;
    logic             pop;

    logic [PTR_W-1:0] rot_idx [NUM_CORES];
    logic [NUM_CORES-1:0] rot_valid;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             accept;

    // rot_idx[gi] is the core visited gi steps after the pointer in the search order.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        logic [PTR_W:0] sum;
        assign sum = {1'b0, ptr_q} + (PTR_W+1)'(gi);
        assign rot_idx[gi] = (sum >= (PTR_W+1)'(NUM_CORES))
                           ? PTR_W'(sum - (PTR_W+1)'(NUM_CORES))
                           : sum[PTR_W-1:0];
        assign rot_valid[gi] = bus.core_valid[rot_idx[gi]];
        assign bus.core_ready[gi] = accept && (grant_idx == PTR_W'(gi));
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = rot_idx[k];
            end
        end
    end

    assign fifo_occ   = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_occ == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_occ == '0);
    assign accept     = grant_any && !fifo_full;
    assign push_data  = {bus.core_h[grant_idx], bus.core_v[grant_idx], bus.core_color[grant_idx]};
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_rtx) begin
        if (accept) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_comb begin
        pop               = 1'b0;
        state_d           = state_q;
        cnt_d             = cnt_q;
        pixel_h_d         = pixel_h_q;
        pixel_v_d         = pixel_v_q;
        new_color_d       = new_color_q;
        new_color_valid_d = 1'b0;
        frame_done_d      = 1'b0;
        pixels_written_d  = pixels_written_q;
        dropped_count_d   = dropped_count_q;

        if (accept) begin
            ptr_d = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if ((32'(head[44:34]) >= SIZE_H) || (32'(head[33:24]) >= SIZE_V)) begin
                        if (dropped_count_q != 16'hFFFF) begin
                            dropped_count_d = dropped_count_q + 16'd1;
                        end
                    end else begin
                        pixel_h_d   = head[44:34];
                        pixel_v_d   = head[33:24];
                        new_color_d = head[23:0];
                        cnt_d       = '0;
                        state_d     = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d             = '0;
                    state_d           = WRITE;
                    new_color_valid_d = 1'b1;
                    // frame_done is raised together with the write pulse it belongs to.
                    frame_done_d      = (pixels_written_q == 21'(TOTAL - 1));
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                state_d          = GAP;
                cnt_d            = '0;
                pixels_written_d = (pixels_written_q == 21'(TOTAL - 1)) ? '0
                                 : pixels_written_q + 21'd1;
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = accept ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk_rtx) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            ptr_q             <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            pixel_h_q         <= '0;
            pixel_v_q         <= '0;
            new_color_q       <= '0;
            new_color_valid_q <= 1'b0;
            frame_done_q      <= 1'b0;
            pixels_written_q  <= '0;
            dropped_count_q   <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            ptr_q             <= ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            pixel_h_q         <= pixel_h_d;
            pixel_v_q         <= pixel_v_d;
            new_color_q       <= new_color_d;
            new_color_valid_q <= new_color_valid_d;
            frame_done_q      <= frame_done_d;
            pixels_written_q  <= pixels_written_d;
            dropped_count_q   <= dropped_count_d;
        end
    end

    assign bus.pixel_h         = pixel_h_q;
    assign bus.pixel_v         = pixel_v_q;
    assign bus.new_color       = new_color_q;
    assign bus.new_color_valid = new_color_valid_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.pixels_written  = pixels_written_q;
    assign bus.dropped_count   = dropped_count_q;
endmodule

// File: tb/tb_rtx_pixel_collector.sv
// Directed bench for rtx_pixel_collector: a full-size instance plus a 4x2 instance
// for frame wrap; cores are fed from per-core item lists, writes checked in order.
module tb_rtx_pixel_collector;
    localparam int HIST = 1024;

    logic clk_rtx = 1'b0;
    logic rst     = 1'b1;
    logic sel     = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;

    always #5 clk_rtx = ~clk_rtx;

    rtx_pixel_collector_if #(.NUM_CORES(4)) bus ();
    rtx_pixel_collector_if #(.NUM_CORES(4)) bus_s ();

    logic [3:0]            drv_valid = '0;
    logic [3:0][10:0]      drv_h     = '0;
    logic [3:0][9:0]       drv_v     = '0;
    logic [3:0][2:0][7:0]  drv_color = '0;

    assign bus.core_valid   = sel ? 4'b0 : drv_valid;
    assign bus_s.core_valid = sel ? drv_valid : 4'b0;
    assign bus.core_h       = drv_h;
    assign bus_s.core_h     = drv_h;
    assign bus.core_v       = drv_v;
    assign bus_s.core_v     = drv_v;
    assign bus.core_color   = drv_color;
    assign bus_s.core_color = drv_color;

    wire [3:0]  o_ready = sel ? bus_s.core_ready      : bus.core_ready;
    wire [10:0] o_h     = sel ? bus_s.pixel_h         : bus.pixel_h;
    wire [9:0]  o_v     = sel ? bus_s.pixel_v         : bus.pixel_v;
    wire [23:0] o_color = sel ? bus_s.new_color       : bus.new_color;
    wire        o_nvc   = sel ? bus_s.new_color_valid : bus.new_color_valid;
    wire        o_fd    = sel ? bus_s.frame_done      : bus.frame_done;
    wire [20:0] o_pw    = sel ? bus_s.pixels_written  : bus.pixels_written;
    wire [15:0] o_drop  = sel ? bus_s.dropped_count   : bus.dropped_count;

    rtx_pixel_collector dut (.clk_rtx(clk_rtx), .rst(rst), .bus(bus));
    rtx_pixel_collector #(.SIZE_H(4), .SIZE_V(2)) dut_s (.clk_rtx(clk_rtx), .rst(rst), .bus(bus_s));

    logic [44:0] items [4][32];
    int          head [4];
    int          tail [4];
    logic [44:0] exp_w [$];
    int          acc_core [$];
    int          acc_cyc [$];
    int          wr_cyc [$];
    logic        stall_seen;
    logic [10:0] ph_hist [HIST];
    logic [9:0]  pv_hist [HIST];
    logic [20:0] pw_hist [HIST];
    logic [15:0] drop_hist [HIST];
    logic        fd_hist [HIST];
    int          t2_order [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_item(input int c, input logic [10:0] h, input logic [9:0] v,
                             input logic [23:0] col, input logic expect_write);
        items[c][tail[c]] = {h, v, col};
        tail[c]++;
        if (expect_write) exp_w.push_back({h, v, col});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            head[c] = 0;
            tail[c] = 0;
        end
        drv_valid = '0;
        drv_h     = '0;
        drv_v     = '0;
        drv_color = '0;
        exp_w.delete();
        acc_core.delete();
        acc_cyc.delete();
        wr_cyc.delete();
        stall_seen = 1'b0;
        repeat (2) @(posedge clk_rtx);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // One iteration = one clock cycle: drive, sample at negedge, advance after posedge.
    task automatic run_cycles(input int n);
        int acc_idx;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                drv_valid[c] = (head[c] < tail[c]);
                if (head[c] < tail[c]) begin
                    drv_h[c]     = items[c][head[c]][44:34];
                    drv_v[c]     = items[c][head[c]][33:24];
                    drv_color[c] = items[c][head[c]][23:0];
                end
            end
            @(negedge clk_rtx);
            if (cyc < HIST) begin
                ph_hist[cyc]   = o_h;
                pv_hist[cyc]   = o_v;
                pw_hist[cyc]   = o_pw;
                drop_hist[cyc] = o_drop;
                fd_hist[cyc]   = o_fd;
            end
            check("ready_legal", 64'(((o_ready & ~drv_valid) == 4'b0) && ($countones(o_ready) <= 1)), 64'd1);
            acc_idx = -1;
            for (int c = 0; c < 4; c++) begin
                if (drv_valid[c] && o_ready[c]) acc_idx = c;
            end
            if (acc_idx >= 0) begin
                acc_core.push_back(acc_idx);
                acc_cyc.push_back(cyc);
            end
            if (drv_valid == 4'hF && o_ready == 4'h0) stall_seen = 1'b1;
            if (o_nvc) begin
                wr_cyc.push_back(cyc);
                $display("write cyc=%0d h=%0d v=%0d color=%06h pw=%0d", cyc, o_h, o_v, o_color, o_pw);
                if (exp_w.size() == 0) check("write_unexpected", 64'(o_nvc), 64'd0);
                else check("write_data", {o_h, o_v, o_color}, exp_w.pop_front());
            end
            @(posedge clk_rtx);
            #1;
            if (acc_idx >= 0) head[acc_idx]++;
            cyc++;
        end
    endtask

    initial begin
        int w7;
        int fd_cnt;
        int base;

        // Reset state
        do_reset();
        check("rst_pixel_h", o_h, 0);
        check("rst_pixel_v", o_v, 0);
        check("rst_new_color", o_color, 0);
        check("rst_nvc", o_nvc, 0);
        check("rst_frame_done", o_fd, 0);
        check("rst_pixels_written", o_pw, 0);
        check("rst_dropped", o_drop, 0);

        // Single result latency
        push_item(0, 11'd5, 10'd3, {8'd10, 8'd20, 8'd30}, 1'b1);
        run_cycles(12);
        check("t1_acc_count", acc_core.size(), 1);
        check("t1_acc_cyc", (acc_cyc.size() > 0) ? acc_cyc[0] : -1, 0);
        check("t1_ph_c1", ph_hist[1], 0);
        check("t1_ph_c2", ph_hist[2], 5);
        check("t1_pv_c2", pv_hist[2], 3);
        check("t1_wr_count", wr_cyc.size(), 1);
        check("t1_wr_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 4);
        check("t1_pw_c4", pw_hist[4], 0);
        check("t1_pw_c5", pw_hist[5], 1);
        check("t1_pending", exp_w.size(), 0);

        // Round-robin order: 0,1,2 then 3 before 0
        do_reset();
        for (int c = 0; c < 3; c++) push_item(c, 11'(100 + c), 10'(10 + c), 24'(c * 3 + 1), 1'b1);
        run_cycles(3);
        push_item(3, 11'd103, 10'd13, 24'd10, 1'b1);
        push_item(0, 11'd104, 10'd14, 24'd13, 1'b1);
        run_cycles(40);
        check("t2_acc_count", acc_core.size(), 5);
        for (int k = 0; k < acc_core.size() && k < 5; k++) begin
            check("t2_acc_order", acc_core[k], t2_order[k]);
            check("t2_acc_cyc", acc_cyc[k], k);
        end
        check("t2_wr_count", wr_cyc.size(), 5);
        check("t2_wr_first", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 4);
        for (int k = 1; k < wr_cyc.size(); k++) check("t2_wr_spacing", wr_cyc[k] - wr_cyc[k-1], 6);
        check("t2_pending", exp_w.size(), 0);

        // Backpressure: all cores valid, 100 pixels
        do_reset();
        for (int idx = 0; idx < 100; idx++)
            push_item(idx % 4, 11'(idx), 10'(idx), {8'(idx), 8'(255 - idx), 8'(idx * 2)}, 1'b1);
        for (int i = 0; i < 700 && wr_cyc.size() < 100; i++) run_cycles(1);
        run_cycles(10);
        check("t3_stall_seen", stall_seen, 1);
        check("t3_acc_count", acc_core.size(), 100);
        check("t3_wr_count", wr_cyc.size(), 100);
        check("t3_pixels_written", o_pw, 100);
        check("t3_pending", exp_w.size(), 0);

        // Out-of-range results are dropped
        do_reset();
        push_item(0, 11'd1280, 10'd0, 24'h111111, 1'b0);
        push_item(0, 11'd7, 10'd8, 24'h222222, 1'b1);
        push_item(0, 11'd0, 10'd720, 24'h333333, 1'b0);
        run_cycles(14);
        check("t4_acc_count", acc_core.size(), 3);
        check("t4_drop_c2", drop_hist[2], 1);
        check("t4_ph_c3", ph_hist[3], 7);
        check("t4_wr_count", wr_cyc.size(), 1);
        check("t4_wr_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 5);
        check("t4_pw_c5", pw_hist[5], 0);
        check("t4_pw_c6", pw_hist[6], 1);
        check("t4_dropped", o_drop, 2);
        check("t4_pixels_written", o_pw, 1);

        // Frame wrap on the 4x2 instance
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 9; k++) push_item(0, 11'(k % 4), 10'((k / 4) % 2), 24'(k + 1), 1'b1);
        run_cycles(60);
        w7 = (wr_cyc.size() > 7) ? wr_cyc[7] : 0;
        fd_cnt = 0;
        for (int c = 0; c < 60; c++) if (fd_hist[c]) fd_cnt++;
        check("t5_wr_count", wr_cyc.size(), 9);
        check("t5_fd_at_8th", fd_hist[w7], 1);
        check("t5_fd_pulses", fd_cnt, 1);
        check("t5_pw_at_8th", pw_hist[w7], 7);
        check("t5_pw_after_8th", pw_hist[w7 + 1], 0);
        check("t5_pw_final", o_pw, 1);
        check("t5_pending", exp_w.size(), 0);
        sel = 1'b0;

        // Reset during SETTLE with three entries queued
        do_reset();
        push_item(0, 11'd50, 10'd1, 24'h505050, 1'b1);
        push_item(1, 11'd51, 10'd1, 24'h515151, 1'b0);
        push_item(2, 11'd52, 10'd1, 24'h525252, 1'b0);
        push_item(3, 11'd53, 10'd1, 24'h535353, 1'b0);
        push_item(0, 11'd54, 10'd1, 24'h545454, 1'b0);
        run_cycles(9);
        rst = 1'b1;
        run_cycles(2);
        rst = 1'b0;
        run_cycles(20);
        check("t6_acc_count", acc_core.size(), 5);
        check("t6_wr_count", wr_cyc.size(), 1);
        check("t6_wr_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 4);
        check("t6_ph_after_rst", ph_hist[10], 0);
        check("t6_pw_after_rst", o_pw, 0);
        base = acc_core.size();
        push_item(0, 11'd60, 10'd2, 24'h606060, 1'b1);
        push_item(1, 11'd61, 10'd2, 24'h616161, 1'b1);
        run_cycles(20);
        check("t6_tie_winner", (acc_core.size() > base) ? acc_core[base] : -1, 0);
        check("t6_wr_total", wr_cyc.size(), 3);
        check("t6_pending", exp_w.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rtx_pixel_collector.md
Name: rtx_pixel_collector

Overview:
- Sits directly upstream of the exponential-averaging frame buffer, in the clk_rtx domain.
- Accepts finished pixel results from NUM_CORES ray-tracing cores through valid/ready handshakes and arbitrates among them round-robin.
- Buffers accepted results in a small FIFO.
- Replays each result to the frame buffer's read-modify-write port with the address held stable around a one-cycle new_color_valid pulse. Also counts written pixels and flags frame completion.

Parameters:
- NUM_CORES, 4, number of tracer result ports (1..8).
- SIZE_H, 1280, horizontal resolution.
- SIZE_V, 720, vertical resolution.
- FIFO_DEPTH, 4, result FIFO entries (power of 2).
- SETTLE_CYCLES, 2, cycles the address is held before the write pulse (≥2, covers BRAM read latency).
- GAP_CYCLES, 2, cycles after the write pulse before the address may change (≥2, covers the frame buffer's 2-cycle write pipeline).

Ports:
- clk_rtx  in  1  ray-tracer clock.
- rst  in  1  synchronous, active-high reset.
- core_valid  in  NUM_CORES  per-core result valid.
- core_ready  out  NUM_CORES  per-core accept; combinational from core_valid, arbiter pointer and FIFO full.
- core_h  in  NUM_CORES x 11  pixel column.
- core_v  in  NUM_CORES x 10  pixel row.
- core_color  in  NUM_CORES x 3 x 8  RGB result.
- pixel_h  out  11  write address column (registered).
- pixel_v  out  10  write address row (registered).
- new_color  out  3 x 8  write colour (registered).
- new_color_valid  out  1  one-cycle write pulse.
- frame_done  out  1  one-cycle pulse when SIZE_H*SIZE_V pixels have been written.
- pixels_written  out  21  in-frame write count.
- dropped_count  out  16  saturating count of out-of-range results.

Behaviour:
- Reset values: all outputs 0; FIFO empty; arbiter pointer 0; FSM in IDLE. Reset asserted mid-operation flushes the FIFO, aborts the FSM, and forces new_color_valid low from the next cycle. In-flight results are lost.
- Arbiter:
  - Search order starts at the pointer and wraps modulo NUM_CORES.
  - First core with core_valid=1 is granted, but only if the FIFO is not full.
  - core_ready is one-hot or zero. A transfer is core_valid & core_ready.
  - After a grant, the pointer becomes granted index+1 (mod NUM_CORES). With no grant, the pointer is unchanged.
  - FIFO full → all core_ready=0.
  - At most one accept per cycle.
- FIFO: 45-bit entries {h,v,color}. Push and pop in the same cycle are allowed when not full or empty. Full/empty flags are registered-pointer based. A push into a full FIFO is impossible by construction.
- Writer FSM: IDLE → SETTLE → WRITE → GAP → IDLE.
  - IDLE: if the FIFO is non-empty, pop.
    - Entry has h≥SIZE_H or v≥SIZE_V: discard it, increment dropped_count (saturate at 0xFFFF), stay in IDLE.
    - Otherwise: load pixel_h/pixel_v/new_color at the clock edge and go to SETTLE.
  - SETTLE: SETTLE_CYCLES cycles, then WRITE.
  - WRITE: exactly one cycle with new_color_valid=1, then GAP.
  - GAP: GAP_CYCLES cycles, then IDLE.
  - pixel_h/pixel_v/new_color hold their values from load through the end of GAP and beyond, until the next load.
- Latency and throughput:
  - Push at cycle t into an empty FIFO with the FSM idle → pop at t+1 → address visible t+2 → new_color_valid at t+2+SETTLE_CYCLES.
  - Steady-state throughput is one write per 1+SETTLE_CYCLES+1+GAP_CYCLES cycles (6 at defaults).
- Back-to-back same address: no special case is needed; GAP_CYCLES guarantees the previous write commits before the next read.
- Counting: each WRITE cycle increments pixels_written.
  - When the increment reaches SIZE_H*SIZE_V, pixels_written wraps to 0 and frame_done pulses high in that same WRITE cycle.
  - Dropped results never count.

Test Plan:
- Single result: core 0 offers (h=5,v=3,color=10/20/30) at cycle 0 → core_ready[0]=1 at cycle 0; pixel_h=5,pixel_v=3 from cycle 2; new_color_valid high only at cycle 4; pixels_written=1 at cycle 5.
- Simultaneous cores 0,1,2 valid, held until accepted → accepts in order 0,1,2 on consecutive cycles. Then with cores 0 and 3 valid → 3 granted before 0. Writes are emitted in the same order, 6 cycles apart.
- Backpressure: all 4 cores valid continuously → FIFO reaches 4 entries and core_ready=0. Afterwards exactly one accept per write, no entry lost or duplicated, 100 pixels in order.
- Out-of-range: h=1280,v=0 pushed → no new_color_valid pulse, dropped_count=1, pixels_written unchanged; next valid pixel is written with normal timing.
- Frame wrap: SIZE_H=4, SIZE_V=2, 8 valid pixels → frame_done pulses in the 8th WRITE cycle, pixels_written=0 afterwards; a 9th pixel gives pixels_written=1.
- Reset during SETTLE with 3 FIFO entries → new_color_valid never pulses for them; after release, the FIFO is empty, pixel_h=0, and the pointer is 0 (core 0 wins a 0/1 tie).
